// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int          INSTR_WIDTH       = 32;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]            pc;
    logic [31:0]            pc4;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   valid;
  } if_id_t;

  typedef enum logic [1:0] {
    IFID_LOAD   = 2'd0,
    IFID_HOLD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } if_id_op_e;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, Imem and IF/ID signals of the fetch stage; master is the fetch stage itself.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic                   stall;
  logic                   flush;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic [31:0]            iaddr;
  logic [INSTR_WIDTH-1:0] idata;
  logic [31:0]            if_id_pc;
  logic [31:0]            if_id_pc4;
  logic [INSTR_WIDTH-1:0] if_id_instr;
  logic                   if_id_valid;
  logic                   misalign;

  modport master (
    input  stall, flush, redirect, redirect_pc, idata,
    output iaddr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign
  );

  modport slave (
    output stall, flush, redirect, redirect_pc, idata,
    input  iaddr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or replace it with a bubble.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  if_id_op_e op_i,
  input  if_id_t    fetch_i,
  output if_id_t    if_id_o
);

  if_id_t if_id_d;
  if_id_t if_id_q;

  // A bubble keeps the pc/pc4 of the squashed slot so decode still sees a coherent PC.
  always_comb begin
    if_id_d = if_id_q;
    case (op_i)
      IFID_LOAD:   if_id_d = fetch_i;
      IFID_HOLD:   if_id_d = if_id_q;
      IFID_BUBBLE: if_id_d = '{pc: fetch_i.pc, pc4: fetch_i.pc4, instr: NOP_INSTR, valid: 1'b0};
      default:     if_id_d = if_id_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_id_q <= '{pc: 32'h0000_0000, pc4: 32'h0000_0000, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_o = if_id_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, sticky misalign flag and IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fetch_stage_if.master bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        misalign_q;
  logic        misalign_d;
  logic        redirect_ok_s;
  if_id_op_e   if_id_op_s;
  if_id_t      fetch_s;
  if_id_t      if_id_s;

  // A stalled cycle drops the redirect; ID re-presents it once the stall clears.
  assign redirect_ok_s = bus.redirect & ~bus.stall;

  always_comb begin
    pc_d = pc_q;
    if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.redirect) begin
      pc_d = word_align(bus.redirect_pc);
    end else begin
      pc_d = pc_inc(pc_q);
    end
  end

  always_comb begin
    if_id_op_s = IFID_LOAD;
    if (bus.flush) begin
      if_id_op_s = IFID_BUBBLE;
    end else if (bus.stall) begin
      if_id_op_s = IFID_HOLD;
    end else begin
      if_id_op_s = IFID_LOAD;
    end
  end

  assign misalign_d = misalign_q | (redirect_ok_s & (bus.redirect_pc[1:0] != 2'b00));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= word_align(RESET_PC);
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign fetch_s = '{pc: pc_q, pc4: pc_inc(pc_q), instr: bus.idata, valid: 1'b1};

  fetch_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .op_i    (if_id_op_s),
    .fetch_i (fetch_s),
    .if_id_o (if_id_s)
  );

  assign bus.iaddr       = pc_q;
  assign bus.if_id_pc    = if_id_s.pc;
  assign bus.if_id_pc4   = if_id_s.pc4;
  assign bus.if_id_instr = if_id_s.instr;
  assign bus.if_id_valid = if_id_s.valid;
  assign bus.misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver queues hand-computed post-edge state, monitor compares.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] iaddr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  fetch_stage_if bus();

  fetch_stage u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] tbl [0:3];
    tbl[0] = 32'h3c01_1001;
    tbl[1] = 32'h343d_0004;
    tbl[2] = 32'h0c10_0012;
    tbl[3] = 32'h0000_0000;
    if (a[31:4] == 28'h0) return tbl[a[3:2]];
    else return {16'hBEEF, a[15:0]};
  endfunction

  assign bus.idata = imem_word(bus.iaddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    check("rst_iaddr", bus.iaddr, 32'h0000_0000);
    check("rst_pc",    bus.if_id_pc, 32'h0000_0000);
    check("rst_pc4",   bus.if_id_pc4, 32'h0000_0000);
    check("rst_instr", bus.if_id_instr, 32'h0000_0000);
    check("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("rst_mis",   {31'd0, bus.misalign}, 32'd0);
  endtask

  task automatic step(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                      input logic [31:0] e_ia, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                      input logic [31:0] e_ins, input logic e_v, input logic e_m);
    exp_t e;
    bus.stall       = st;
    bus.flush       = fl;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    e.iaddr = e_ia; e.pc = e_pc; e.pc4 = e_pc4; e.instr = e_ins; e.valid = e_v; e.mis = e_m;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge with a pending expectation is compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("iaddr", bus.iaddr, e.iaddr);
        check("if_id_pc", bus.if_id_pc, e.pc);
        check("if_id_pc4", bus.if_id_pc4, e.pc4);
        check("if_id_instr", bus.if_id_instr, e.instr);
        check("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
        check("misalign", {31'd0, bus.misalign}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    #3;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // st fl rd rpc            iaddr         pc            pc4           instr         v     mis
    step(0, 0, 0, 32'h0,       32'h04,       32'h00,       32'h04,       32'h3c011001, 1'b1, 1'b0);
    step(0, 0, 0, 32'h0,       32'h08,       32'h04,       32'h08,       32'h343d0004, 1'b1, 1'b0);
    step(1, 0, 0, 32'h0,       32'h08,       32'h04,       32'h08,       32'h343d0004, 1'b1, 1'b0);
    step(1, 0, 1, 32'h48,      32'h08,       32'h04,       32'h08,       32'h343d0004, 1'b1, 1'b0);
    step(0, 0, 1, 32'h48,      32'h48,       32'h08,       32'h0C,       32'h0c100012, 1'b1, 1'b0);
    step(0, 0, 0, 32'h0,       32'h4C,       32'h48,       32'h4C,       32'hBEEF0048, 1'b1, 1'b0);
    step(0, 0, 1, 32'h04,      32'h04,       32'h4C,       32'h50,       32'hBEEF004C, 1'b1, 1'b0);
    step(0, 1, 0, 32'h0,       32'h08,       32'h04,       32'h08,       32'h00000000, 1'b0, 1'b0);
    step(1, 1, 0, 32'h0,       32'h08,       32'h08,       32'h0C,       32'h00000000, 1'b0, 1'b0);
    step(0, 0, 0, 32'h0,       32'h0C,       32'h08,       32'h0C,       32'h0c100012, 1'b1, 1'b0);
    step(1, 0, 1, 32'h4A,      32'h0C,       32'h08,       32'h0C,       32'h0c100012, 1'b1, 1'b0);
    step(0, 0, 1, 32'h4A,      32'h48,       32'h0C,       32'h10,       32'h00000000, 1'b1, 1'b1);
    step(0, 0, 1, 32'h04,      32'h04,       32'h48,       32'h4C,       32'hBEEF0048, 1'b1, 1'b1);
    step(0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h04,      32'h08,       32'h343d0004, 1'b1, 1'b1);
    step(0, 0, 0, 32'h0,       32'h00,       32'hFFFFFFFC, 32'h00,       32'hBEEFFFFC, 1'b1, 1'b1);
    step(0, 0, 0, 32'h0,       32'h04,       32'h00,       32'h04,       32'h3c011001, 1'b1, 1'b1);

    rst_n = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 32'h0,       32'h04,       32'h00,       32'h04,       32'h3c011001, 1'b1, 1'b0);
    step(0, 0, 0, 32'h0,       32'h08,       32'h04,       32'h08,       32'h343d0004, 1'b1, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
